// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with a one-entry registered response buffer under valid/ready backpressure.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;
endpackage

module alu (
  input  alu_pkg::alu_op_e op_i,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  output logic [31:0]      result_o,
  output logic             zero_o,
  output logic             overflow_o
);
  import alu_pkg::*;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o   = a_i + b_i;
        overflow_o = (a_i[31] == b_i[31]) && (result_o[31] != a_i[31]);
      end
      ALU_SUB: begin
        result_o   = a_i - b_i;
        overflow_o = (a_i[31] != b_i[31]) && (result_o[31] != a_i[31]);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      // Encodings outside the enum have no defined result.
      default:  result_o = 'x;
    endcase
    zero_o = (result_o == '0);
  end
endmodule

module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic             [NUM_REQ-1:0]       req_valid_i,
  output logic             [NUM_REQ-1:0]       req_ready_o,
  input  alu_pkg::alu_op_e [NUM_REQ-1:0]       req_op_i,
  input  logic             [NUM_REQ-1:0][31:0] req_a_i,
  input  logic             [NUM_REQ-1:0][31:0] req_b_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic             [ID_W-1:0]          rsp_id_o,
  output logic             [31:0]              rsp_result_o,
  output logic                                 rsp_zero_o,
  output logic                                 rsp_overflow_o
);
  import alu_pkg::*;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_overflow_q, rsp_overflow_d;

  logic              can_accept;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              fire;

  alu_op_e           alu_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              alu_overflow;

  // Scan from rr_ptr upward, wrapping at NUM_REQ-1 so non-power-of-two counts work.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid_i[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    can_accept  = (state_q == ST_EMPTY) || rsp_ready_i;
    fire        = rst_ni && can_accept && grant_valid;
    req_ready_o = '0;
    if (fire) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    alu_op = req_op_i[grant_idx];
    alu_a  = req_a_i[grant_idx];
    alu_b  = req_b_i[grant_idx];
  end

  alu u_alu (
    .op_i       (alu_op),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    if (fire) begin
      state_d        = ST_FULL;
      rsp_id_d       = grant_idx;
      rsp_result_d   = alu_result;
      rsp_zero_d     = alu_zero;
      rsp_overflow_d = alu_overflow;
      rr_ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == ST_FULL) && rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_EMPTY;
      rr_ptr_q       <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

  assign rsp_valid_o    = (state_q == ST_FULL);
  assign rsp_id_o       = rsp_id_q;
  assign rsp_result_o   = rsp_result_q;
  assign rsp_zero_o     = rsp_zero_q;
  assign rsp_overflow_o = rsp_overflow_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with four requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  logic                       clk;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  alu_op_e [NREQ-1:0]         req_op;
  logic [NREQ-1:0][31:0]      req_a;
  logic [NREQ-1:0][31:0]      req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [1:0]                 rsp_id;
  logic [31:0]                rsp_result;
  logic                       rsp_zero;
  logic                       rsp_overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs[$];

  alu_arbiter #(.NUM_REQ(NREQ)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_result_o   (rsp_result),
    .rsp_zero_o     (rsp_zero),
    .rsp_overflow_o (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req_op[i] = ALU_ADD;
      req_a[i]  = '0;
      req_b[i]  = '0;
    end

    // Reset state; ready forced low while reset is asserted.
    @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_result", rsp_result, 32'h0);
    check("rst_zero", 32'(rsp_zero), 32'h0);
    check("rst_ovf", 32'(rsp_overflow), 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Idle: nothing granted, nothing produced.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'h0);
      check("idle_valid", 32'(rsp_valid), 32'h0);
      check("idle_result", rsp_result, 32'h0);
    end

    // Single request from requester 1.
    req_op[1] = ALU_ADD; req_a[1] = 32'd5; req_b[1] = 32'd7;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1 check("t2_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("t2_valid", 32'(rsp_valid), 32'h1);
    check("t2_id", 32'(rsp_id), 32'h1);
    check("t2_result", rsp_result, 32'd12);
    check("t2_zero", 32'(rsp_zero), 32'h0);
    check("t2_ovf", 32'(rsp_overflow), 32'h0);
    req_valid = '0;
    @(negedge clk);
    check("t2_drained", 32'(rsp_valid), 32'h0);

    // Two contending requesters from reset.
    do_reset();
    req_op[0] = ALU_SUB; req_a[0] = 32'd3;          req_b[0] = 32'd3;
    req_op[1] = ALU_ADD; req_a[1] = 32'h7FFF_FFFF;  req_b[1] = 32'd1;
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    #1 check("t3_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("t3_id0", 32'(rsp_id), 32'h0);
    check("t3_res0", rsp_result, 32'h0);
    check("t3_zero0", 32'(rsp_zero), 32'h1);
    check("t3_ovf0", 32'(rsp_overflow), 32'h0);
    check("t3_ready1", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("t3_id1", 32'(rsp_id), 32'h1);
    check("t3_res1", rsp_result, 32'h8000_0000);
    check("t3_zero1", 32'(rsp_zero), 32'h0);
    check("t3_ovf1", 32'(rsp_overflow), 32'h1);
    check("t3_ready2", 32'(req_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_alt_id", 32'(rsp_id), 32'(k % 2));
      check("t3_alt_valid", 32'(rsp_valid), 32'h1);
    end

    // Backpressure: hold a full buffer, then drain and refill together.
    req_op[0] = ALU_ADD; req_a[0] = 32'd10; req_b[0] = 32'd20;
    req_valid = 4'b0001;
    #1 check("t4_ready_fill", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("t4_res_first", rsp_result, 32'd30);
    rsp_ready = 1'b0;
    req_op[0] = ALU_XOR; req_a[0] = 32'h0000_F0F0; req_b[0] = 32'h0000_0FF0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_bp_ready", 32'(req_ready), 32'h0);
      check("t4_bp_valid", 32'(rsp_valid), 32'h1);
      check("t4_bp_id", 32'(rsp_id), 32'h0);
      check("t4_bp_result", rsp_result, 32'd30);
      check("t4_bp_zero", 32'(rsp_zero), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("t4_refill_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("t4_refill_valid", 32'(rsp_valid), 32'h1);
    check("t4_refill_result", rsp_result, 32'h0000_FF00);
    req_valid = '0;
    @(negedge clk);
    check("t4_empty", 32'(rsp_valid), 32'h0);

    // Back-to-back operation table through requester 3.
    vecs.push_back('{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0});
    vecs.push_back('{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0});
    vecs.push_back('{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0});
    vecs.push_back('{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0});
    vecs.push_back('{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0});
    vecs.push_back('{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0});
    req_valid = 4'b1000;
    foreach (vecs[i]) begin
      req_op[3] = vecs[i].op;
      req_a[3]  = vecs[i].a;
      req_b[3]  = vecs[i].b;
      @(negedge clk);
      check("vec_valid", 32'(rsp_valid), 32'h1);
      check("vec_id", 32'(rsp_id), 32'h3);
      check("vec_result", rsp_result, vecs[i].r);
      check("vec_zero", 32'(rsp_zero), 32'(vecs[i].z));
      check("vec_ovf", 32'(rsp_overflow), 32'(vecs[i].v));
    end

    // Undefined opcode still completes the handshake with a valid ID.
    req_op[2]  = alu_op_e'(4'hF);
    req_valid  = 4'b0100;
    #1 check("undef_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    check("undef_valid", 32'(rsp_valid), 32'h1);
    check("undef_id", 32'(rsp_id), 32'h2);
    req_valid = '0;

    // All four valid: grants rotate 0,1,2,3,0,1 with SLT results tagged by ID.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_op[i] = ALU_SLT;
      req_a[i]  = 32'(i - 1);
      req_b[i]  = 32'd1;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 check("rr_ready_first", 32'(req_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_result", rsp_result, ((k % 4) < 2) ? 32'd1 : 32'd0);
      check("rr_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Reset while full and stalled discards the response and rr_ptr.
    req_op[1] = ALU_ADD; req_a[1] = 32'd5; req_b[1] = 32'd7;
    req_valid = 4'b0010;
    @(negedge clk);
    check("t6_full_id", 32'(rsp_id), 32'h1);
    check("t6_full_result", rsp_result, 32'd12);
    rsp_ready = 1'b0;
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(rsp_valid), 32'h0);
    check("t6_rst_id", 32'(rsp_id), 32'h0);
    check("t6_rst_result", rsp_result, 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1 check("t6_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("t6_first_id", 32'(rsp_id), 32'h0);
    check("t6_first_valid", 32'(rsp_valid), 32'h1);
    check("t6_first_result", rsp_result, 32'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
